imem_loader: RTL and testbench

Writer side of the byte-addressed instruction memory. Accepts a little-endian byte stream over a valid/ready handshake and issues one byte write per accepted byte to the instruction memory's write port at incrementing addresses from 0. Holds the CPU until the program is fully written. Sits between the host/debug byte source and the instruction memory; the fetch stage reads the memory after `cpu_hold` drops.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_word_assembler.sv | 51 +++++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: types and constants shared by the instruction-memory loader.
//   state_e    - loader FSM states
//   WORD_BYTES - bytes per instruction word
//   LEN_CHK_W  - width used for the byte-length product and the byte counter.
//                It holds len_words*4 for any 16-bit len_words without truncation.
package imem_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam int LEN_CHK_W  = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_e;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: builds little-endian 32-bit words from a byte stream and
// XOR-accumulates each completed word into a running checksum.
// This module exists only in builds where IMEM_LOADER_CHECKSUM_EN is defined.
//   clk, rst           - clock, async active-high reset
//   clr                - synchronous clear of the word and the checksum
//   byte_vld           - a byte is accepted this cycle
//   byte_last          - the accepted byte is the top byte of its word
//   byte_data          - the accepted byte
//   checksum           - XOR of all completed words
`ifdef IMEM_LOADER_CHECKSUM_EN
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      byte_vld,
  input  logic                      byte_last,
  input  logic [7:0]                byte_data,
  output logic [8*WORD_BYTES-1:0]   checksum
);
  logic [8*WORD_BYTES-1:0] word_q, word_d, sum_q, sum_d, word_next;

  // New bytes enter at the top, so after four bytes word = {b3,b2,b1,b0}.
  assign word_next = {byte_data, word_q[8*WORD_BYTES-1:8]};

  always_comb begin
    word_d = word_q;
    sum_d  = sum_q;
    if (clr) begin
      word_d = '0;
      sum_d  = '0;
    end else if (byte_vld) begin
      word_d = word_next;
      if (byte_last) sum_d = sum_q ^ word_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      sum_q  <= '0;
    end else begin
      word_q <= word_d;
      sum_q  <= sum_d;
    end
  end

  assign checksum = sum_q;
endmodule
`endif

// File: rtl/imem_loader.sv
// imem_loader: writes a little-endian byte stream into the instruction memory
// at addresses 0,1,2,... and holds the CPU until the program is complete.
// Optional checksum output is enabled by defining IMEM_LOADER_CHECKSUM_EN.
//   clk, reset          - clock, async active-high reset
//   start, len_words    - begin a load of len_words 32-bit words
//   in_valid/in_ready   - byte stream handshake, in_data carries the byte
//   mem_we/addr/wdata   - registered byte write port to the memory
//   busy, done, error   - status (LOAD/FLUSH, finished, rejected)
//   cpu_hold            - CPU must not fetch while high
//   checksum            - XOR of loaded words (optional)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,output logic [31:0]      checksum
`endif
);
  state_e                 state_q, state_d;
  logic [LEN_CHK_W-1:0]   cnt_q, cnt_d;
  logic [LEN_CHK_W-1:0]   last_q, last_d;
  logic [LEN_CHK_W-1:0]   len_bytes;
  logic [LEN_CHK_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic                   start_ok, accept;

  // Full-width product so large len_words can never alias to a small length.
  assign len_bytes = LEN_CHK_W'(len_words) * LEN_CHK_W'(WORD_BYTES);
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign accept    = (state_q == S_LOAD) && in_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          cnt_d = '0;
          if (len_bytes == '0)                                state_d = S_DONE;
          else if (len_bytes > LEN_CHK_W'(DEPTH_BYTES))       state_d = S_ERROR;
          else begin
            state_d = S_LOAD;
            last_d  = len_bytes - 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == last_q) state_d = S_FLUSH;
        end
      end
      // Final write is on the port this cycle; memory captures it at the edge.
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Status is decoded from the registered state, so it is glitch-free and
  // in_ready drops in the FLUSH cycle right after the last byte.
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_hold  = (state_q != S_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = ADDR_W'(mem_addr_q);
  assign mem_wdata = mem_wdata_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  imem_word_assembler u_asm (
    .clk       (clk),
    .rst       (reset),
    .clr       (start_ok),
    .byte_vld  (accept),
    .byte_last (cnt_q[1:0] == 2'b11),
    .byte_data (in_data),
    .checksum  (checksum)
  );
`endif
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [15:0] len_words;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error, cpu_hold;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] stream [DEPTH];
  logic [7:0] mem    [DEPTH];
  int wr_cnt = 0;
  int last_addr = -1;

  typedef struct {
    logic [15:0] len;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
    int          writes;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and log any write on the memory port.
  // Each write is held for exactly one cycle, so it is seen exactly once here.
  task automatic tick();
    @(negedge clk);
    if (mem_we === 1'b1) begin
      chk("wr_addr", mem_addr, 64'(wr_cnt));
      chk("wr_data", {56'h0, mem_wdata}, {56'h0, stream[wr_cnt % DEPTH]});
      mem[mem_addr[6:0]] = mem_wdata;
      last_addr = int'(mem_addr[31:0]);
      wr_cnt++;
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start = 1'b1;
    len_words = len;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_load(input logic [15:0] len);
    wr_cnt = 0;
    last_addr = -1;
    pulse_start(len);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  endtask

  // Send n stream bytes starting at index first, with gap idle cycles after each.
  task automatic send(input int n, input int first, input int gap);
    for (int i = first; i < first + n; i++) begin
      int t = 0;
      while (in_ready !== 1'b1 && t < 20) begin tick(); t++; end
      if (t >= 20) begin
        chk("in_ready_timeout", 64'(in_ready), 64'h1);
        return;
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      tick();
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_we", 64'(mem_we), 64'h0);
      end
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; len_words = '0; in_data = '0;
    for (int i = 0; i < DEPTH; i++) stream[i] = 8'(i * 37 + 5);
    stream[0] = 8'h93; stream[1] = 8'h02; stream[2] = 8'h00; stream[3] = 8'h10;
    stream[4] = 8'h13; stream[5] = 8'h03; stream[6] = 8'h70; stream[7] = 8'h00;
    clear_mem();

    vecs[0] = '{16'd2,      1'b1, 1'b0, 1'b0, 8};
    vecs[1] = '{16'd1,      1'b1, 1'b0, 1'b0, 4};
    vecs[2] = '{16'd33,     1'b0, 1'b1, 1'b1, 0};
    vecs[3] = '{16'd32,     1'b1, 1'b0, 1'b0, 128};
    vecs[4] = '{16'd0,      1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{16'h4001,   1'b0, 1'b1, 1'b1, 0};
    vecs[6] = '{16'hFFFF,   1'b0, 1'b1, 1'b1, 0};

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_mem_we",   64'(mem_we),   64'h0);
    chk("rst_mem_addr", mem_addr,      64'h0);
    chk("rst_busy",     64'(busy),     64'h0);
    chk("rst_done",     64'(done),     64'h0);
    chk("rst_error",    64'(error),    64'h0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Nominal load with exact FLUSH/DONE timing
    begin_load(16'd2);
    chk("nom_in_ready", 64'(in_ready), 64'h1);
    send(8, 0, 0);
    chk("flush_busy",     64'(busy),     64'h1);
    chk("flush_in_ready", 64'(in_ready), 64'h0);
    chk("flush_addr",     mem_addr,      64'd7);
    chk("flush_done",     64'(done),     64'h0);
    chk("flush_hold",     64'(cpu_hold), 64'h1);
    tick();
    chk("nom_done",  64'(done),     64'h1);
    chk("nom_hold",  64'(cpu_hold), 64'h0);
    chk("nom_busy",  64'(busy),     64'h0);
    chk("nom_we",    64'(mem_we),   64'h0);
    chk("nom_w0",    64'(word(0)),  64'h10000293);
    chk("nom_w1",    64'(word(1)),  64'h00700313);
    chk("nom_count", 64'(wr_cnt),   64'd8);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("nom_checksum", 64'(checksum), 64'h10700180);
`endif

    // Backpressure: 3 idle cycles between bytes
    clear_mem();
    begin_load(16'd2);
    send(8, 0, 3);
    chk("bp_count", 64'(wr_cnt),  64'd8);
    chk("bp_done",  64'(done),    64'h1);
    chk("bp_w0",    64'(word(0)), 64'h10000293);
    chk("bp_w1",    64'(word(1)), 64'h00700313);

    // Table-driven lengths; an extra byte is offered after each load/reject
    foreach (vecs[v]) begin
      begin_load(vecs[v].len);
      if (vecs[v].writes > 0) send(vecs[v].writes, 0, 0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (3) tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_done", v),  64'(done),     64'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), 64'(error),    64'(vecs[v].exp_err));
      chk($sformatf("v%0d_hold", v),  64'(cpu_hold), 64'(vecs[v].exp_hold));
      chk($sformatf("v%0d_busy", v),  64'(busy),     64'h0);
      chk($sformatf("v%0d_writes", v), 64'(wr_cnt),  64'(vecs[v].writes));
      if (vecs[v].writes > 0)
        chk($sformatf("v%0d_last_addr", v), 64'(last_addr), 64'(vecs[v].writes - 1));
    end

    // Reset after 5 of 8 bytes: outputs return to reset values at once
    begin_load(16'd2);
    send(5, 0, 0);
    chk("pre_rst_we", 64'(mem_we), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",       64'(mem_we),    64'h0);
    chk("mid_rst_addr",     mem_addr,       64'h0);
    chk("mid_rst_wdata",    64'(mem_wdata), 64'h0);
    chk("mid_rst_in_ready", 64'(in_ready),  64'h0);
    chk("mid_rst_busy",     64'(busy),      64'h0);
    chk("mid_rst_done",     64'(done),      64'h0);
    chk("mid_rst_hold",     64'(cpu_hold),  64'h1);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_hold", 64'(cpu_hold), 64'h1);

    // Zero length from IDLE: DONE next cycle, no writes, in_ready stays low
    begin_load(16'd0);
    chk("zero_done",     64'(done),     64'h1);
    chk("zero_hold",     64'(cpu_hold), 64'h0);
    chk("zero_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("zero_in_ready2", 64'(in_ready), 64'h0);
    chk("zero_writes",    64'(wr_cnt),   64'd0);

    // Rewrite from address 0 after the reset
    clear_mem();
    begin_load(16'd2);
    send(8, 0, 0);
    tick();
    chk("rewr_count", 64'(wr_cnt),  64'd8);
    chk("rewr_w0",    64'(word(0)), 64'h10000293);
    chk("rewr_w1",    64'(word(1)), 64'h00700313);
    chk("rewr_done",  64'(done),    64'h1);

    // start during LOAD is ignored; an extra byte after the last is refused
    clear_mem();
    begin_load(16'd2);
    send(3, 0, 0);
    pulse_start(16'd1);
    chk("ign_busy",     64'(busy),     64'h1);
    chk("ign_in_ready", 64'(in_ready), 64'h1);
    send(5, 3, 0);
    chk("extra_flush_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("extra_in_ready", 64'(in_ready), 64'h0);
    end
    in_valid = 1'b0;
    chk("ign_count", 64'(wr_cnt),  64'd8);
    chk("ign_done",  64'(done),    64'h1);
    chk("ign_w1",    64'(word(1)), 64'h00700313);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
